// File: rtl/alu_seq_if.sv
// Request handshake plus operand/result bus between alu_seq and an external ALU.
// The master side issues requests and computes ALU results; the slave is the sequencer.
// Flags and result are returned combinationally from the operands the sequencer drives.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [2:0]  req_rd;
  logic [2:0]  req_rs1;
  logic [2:0]  req_rs2;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_carry;
  logic        alu_overflow;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_negative, alu_carry, alu_overflow
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2,
    output req_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_negative, alu_carry, alu_overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Register-file sequencer around an external ALU: IDLE -> READ -> EXEC -> WB.
// Latency: accept edge T, done during cycle after T+2, result/flags visible after T+3.
// Backpressure: req_ready high only in IDLE; requests seen in other states are ignored.
module alu_seq #(
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        done,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic [15:0] regs [NREG];
  logic [2:0]  op_q, rd_q, rs1_q, rs2_q;
  logic [15:0] res_q;
  logic [3:0]  flg_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/done outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields when accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q  <= bus.req_op;
      rd_q  <= bus.req_rd;
      rs1_q <= bus.req_rs1;
      rs2_q <= bus.req_rs2;
    end
  end

  // Operands to the ALU change only on the READ edge; a same-edge ld is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
    end else if (state == READ) begin
      bus.alu_a  <= regs[rs1_q];
      bus.alu_b  <= regs[rs2_q];
      bus.alu_op <= op_q;
    end
  end

  // Hold the ALU result and flags sampled on the EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (state == EXEC) begin
      res_q <= bus.alu_result;
      flg_q <= {bus.alu_zero, bus.alu_negative, bus.alu_carry, bus.alu_overflow};
    end
  end

  // Register file: direct load first, writeback second so WB wins on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (ld_en)         regs[ld_addr] <= ld_data;
      if (state == WB)   regs[rd_q]    <= res_q;
    end
  end

  // Status register updates on every writeback, whatever the opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            flags <= '0;
    else if (state == WB)  flags <= flg_q;
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural external ALU.
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR.
// Expected values are hand-computed constants.
module tb_alu_seq;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SHL = 3'b110, OP_SHR = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        done;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_if bus ();

  alu_seq #(.NREG(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .done     (done),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  // External ALU model.
  logic [16:0] sum;
  always_comb begin
    sum                = '0;
    bus.alu_result     = '0;
    bus.alu_carry      = 1'b0;
    bus.alu_overflow   = 1'b0;
    case (bus.alu_op)
      3'b000: begin
        sum              = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result   = sum[15:0];
        bus.alu_carry    = sum[16];
        bus.alu_overflow = (bus.alu_a[15] == bus.alu_b[15]) && (sum[15] != bus.alu_a[15]);
      end
      3'b001: begin
        sum              = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        bus.alu_result   = sum[15:0];
        bus.alu_carry    = sum[16];
        bus.alu_overflow = (bus.alu_a[15] != bus.alu_b[15]) && (sum[15] != bus.alu_a[15]);
      end
      3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b101: bus.alu_result = ~bus.alu_a;
      3'b110: begin
        bus.alu_result = {bus.alu_a[14:0], 1'b0};
        bus.alu_carry  = bus.alu_a[15];
      end
      default: begin
        bus.alu_result = {1'b0, bus.alu_a[15:1]};
        bus.alu_carry  = bus.alu_a[0];
      end
    endcase
    bus.alu_zero     = (bus.alu_result == 16'h0000);
    bus.alu_negative = bus.alu_result[15];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic drive_req(input logic v, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
  endtask

  // Accept one op, measure edges from accept to done, then complete writeback.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2);
    int n;
    drive_req(1'b1, op, rd, rs1, rs2);
    tick;
    bus.req_valid = 1'b0;
    ld_en = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, n, 2);
    tick;
    check({tag, "_done_drop"}, {31'h0, done}, 0);
  endtask

  // Op with a direct load applied during the READ cycle (phase 1) or WB cycle (phase 3).
  task automatic op_with_ld(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input int phase,
                            input logic [2:0] la, input logic [15:0] ldv);
    drive_req(1'b1, op, rd, rs1, rs2);
    tick;
    bus.req_valid = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      if (p == phase) begin
        ld_en = 1'b1; ld_addr = la; ld_data = ldv;
      end
      tick;
      ld_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    drive_req(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    #2;
    check("rst_ready", {31'h0, bus.req_ready}, 1);
    check("rst_done",  {31'h0, done}, 0);
    check("rst_flags", {28'h0, flags}, 0);
    check("rst_alu_a", {16'h0, bus.alu_a}, 0);
    check("rst_alu_op", {29'h0, bus.alu_op}, 0);
    check_reg("rst_r0", 3'd0, 16'h0000);
    #8 rst_n = 1'b1;

    // ADD overflow into the sign bit.
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    drive_req(1'b1, OP_ADD, 3'd3, 3'd1, 3'd2);
    tick;
    bus.req_valid = 1'b0;
    check("add_ready_read", {31'h0, bus.req_ready}, 0);
    tick;
    check("add_alu_a",  {16'h0, bus.alu_a}, 32'h7FFF);
    check("add_alu_b",  {16'h0, bus.alu_b}, 32'h0001);
    check("add_alu_op", {29'h0, bus.alu_op}, 0);
    tick;
    check("add_done", {31'h0, done}, 1);
    tick;
    check("add_done_drop", {31'h0, done}, 0);
    check_reg("add_r3", 3'd3, 16'h8000);
    check("add_flags", {28'h0, flags}, 32'b0101);
    check("add_alu_a_hold", {16'h0, bus.alu_a}, 32'h7FFF);

    // SUB with rs1 == rs2.
    load(3'd4, 16'h0005);
    run_op("sub", OP_SUB, 3'd5, 3'd4, 3'd4);
    check_reg("sub_r5", 3'd5, 16'h0000);
    check("sub_flags", {28'h0, flags}, 32'b1010);

    // Shifts in place, rd == rs1.
    load(3'd1, 16'h8001);
    run_op("shl", OP_SHL, 3'd1, 3'd1, 3'd0);
    check_reg("shl_r1", 3'd1, 16'h0002);
    check("shl_flags", {28'h0, flags}, 32'b0010);
    run_op("shr", OP_SHR, 3'd1, 3'd1, 3'd0);
    check_reg("shr_r1", 3'd1, 16'h0001);
    check("shr_flags", {28'h0, flags}, 32'b0000);

    // Held request: two back-to-back ADDs r6 += r2, four cycles apart.
    drive_req(1'b1, OP_ADD, 3'd6, 3'd6, 3'd2);
    tick;
    for (int k = 0; k < 3; k++) begin
      check("b2b_ready_busy", {31'h0, bus.req_ready}, 0);
      check("b2b_done", {31'h0, done}, (k == 2) ? 1 : 0);
      tick;
    end
    check("b2b_ready_idle", {31'h0, bus.req_ready}, 1);
    check_reg("b2b_r6_first", 3'd6, 16'h0001);
    tick;
    bus.req_valid = 1'b0;
    check("b2b_ready_second", {31'h0, bus.req_ready}, 0);
    tick; tick;
    check("b2b_done2", {31'h0, done}, 1);
    tick;
    check_reg("b2b_r6_second", 3'd6, 16'h0002);

    // ld vs WB on the same address: WB wins (r1 + r2 = 2).
    op_with_ld(OP_ADD, 3'd6, 3'd1, 3'd2, 3, 3'd6, 16'h1234);
    check_reg("wb_wins_r6", 3'd6, 16'h0002);
    // ld vs WB on different addresses: both land (r6 + r2 = 3).
    op_with_ld(OP_ADD, 3'd6, 3'd6, 3'd2, 3, 3'd7, 16'hBEEF);
    check_reg("both_r6", 3'd6, 16'h0003);
    check_reg("both_r7", 3'd7, 16'hBEEF);
    // ld to the source on the READ edge: operand uses old r4 (5 + 5).
    op_with_ld(OP_ADD, 3'd0, 3'd4, 3'd4, 1, 3'd4, 16'h0100);
    check_reg("read_ld_r0", 3'd0, 16'h000A);
    check_reg("read_ld_r4", 3'd4, 16'h0100);

    // Reset during EXEC of ADD rd=2.
    drive_req(1'b1, OP_ADD, 3'd2, 3'd7, 3'd7);
    tick;
    bus.req_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, bus.req_ready}, 1);
    check("mid_rst_alu_a", {16'h0, bus.alu_a}, 0);
    #2 rst_n = 1'b1;
    check("mid_rst_done", {31'h0, done}, 0);
    check_reg("mid_rst_r2", 3'd2, 16'h0000);
    check_reg("mid_rst_r7", 3'd7, 16'h0000);
    check("mid_rst_flags", {28'h0, flags}, 0);
    tick;
    check("post_rst_done", {31'h0, done}, 0);
    check_reg("post_rst_r2", 3'd2, 16'h0000);
    check("post_rst_flags", {28'h0, flags}, 0);

    // Request on the first edge after release, with a same-edge load of the operand.
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0003;
    run_op("first", OP_ADD, 3'd3, 3'd1, 3'd1);
    check_reg("first_r3", 3'd3, 16'h0006);
    check("first_flags", {28'h0, flags}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
